// File: rtl/tile_layer_pkg.sv
// Shared types and geometry for the tiled background layer: map entry layout,
// pipeline stage records, default map geometry and the renderer latency.
package tile_layer_pkg;

  localparam int DEF_TILE_W      = 16;
  localparam int DEF_TILE_H      = 16;
  localparam int DEF_MAP_COLS    = 40;
  localparam int DEF_MAP_ROWS    = 30;
  localparam int DEF_TILE_IDX_W  = 7;
  localparam int DEF_COLOR_IDX_W = 6;

  localparam int COORD_W   = 10;
  localparam int MAP_PIX_W = DEF_MAP_COLS * DEF_TILE_W;
  localparam int MAP_PIX_H = DEF_MAP_ROWS * DEF_TILE_H;

  // Cycles from DrawX/DrawY/blank sampling to RGB; hsync/vsync are delayed by this much.
  localparam int LATENCY = 4;

  typedef struct packed {
    logic                      flip_y;
    logic                      flip_x;
    logic [DEF_TILE_IDX_W-1:0] tile_idx;
  } map_entry_t;

  typedef struct packed {
    logic               blank;
    logic [COORD_W-1:0] tx;
    logic [COORD_W-1:0] ty;
    logic [COORD_W-1:0] fx;
    logic [COORD_W-1:0] fy;
  } s0_t;

  typedef struct packed {
    logic               blank;
    logic [COORD_W-1:0] fx;
    logic [COORD_W-1:0] fy;
  } s1_t;

  // Screen coordinate plus scroll, wrapped once; valid because pos < span and offs < span.
  function automatic logic [COORD_W:0] wrap_coord(input logic [COORD_W-1:0] pos,
                                                  input logic [COORD_W-1:0] offs,
                                                  input int span);
    logic [COORD_W:0] sum;
    sum = {1'b0, pos} + {1'b0, offs};
    if (sum >= (COORD_W+1)'(span))
      sum = sum - (COORD_W+1)'(span);
    return sum;
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port tile map RAM: one write and one synchronous read per cycle,
// read-first on an address collision. Contents are not reset.
module tile_map_ram #(
  parameter int DEPTH  = 1200,
  parameter int DATA_W = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  // Both assignments are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/tile_palette.sv
// Combinational palette: maps a 6-bit colour index to 4:4:4 RGB.
module tile_palette #(
  parameter int COLOR_IDX_W = 6
) (
  input  logic [COLOR_IDX_W-1:0] i_idx,
  output logic [3:0]             o_red,
  output logic [3:0]             o_green,
  output logic [3:0]             o_blue
);

  assign o_red   = i_idx[3:0];
  assign o_green = i_idx[5:2];
  assign o_blue  = i_idx[3:0] ^ i_idx[5:2];

endmodule

// File: rtl/tile_rom.sv
// Tile pixel ROM: TILE_W x TILE_H colour indices per tile, addressed as
// {tile_idx, row, column}, with a registered output. Tile 0 is fully transparent.
module tile_rom #(
  parameter int TILE_W      = 16,
  parameter int TILE_H      = 16,
  parameter int TILE_IDX_W  = 7,
  parameter int COLOR_IDX_W = 6,
  localparam int FX_W       = $clog2(TILE_W),
  localparam int FY_W       = $clog2(TILE_H),
  localparam int ROM_AW     = TILE_IDX_W + FY_W + FX_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ROM_AW-1:0]      i_addr,
  output logic [COLOR_IDX_W-1:0] o_data
);

  logic [TILE_IDX_W-1:0] w_tile;
  logic [FY_W-1:0]       w_row;
  logic [FX_W-1:0]       w_col;

  assign w_tile = i_addr[ROM_AW-1 -: TILE_IDX_W];
  assign w_row  = i_addr[FX_W +: FY_W];
  assign w_col  = i_addr[FX_W-1:0];

  // Procedural test pattern: every pixel of a non-zero tile has a non-zero index.
  function automatic logic [COLOR_IDX_W-1:0] pixelAt(input logic [TILE_IDX_W-1:0] t,
                                                     input logic [FY_W-1:0] y,
                                                     input logic [FX_W-1:0] x);
    int v;
    if (t == '0)
      return '0;
    v = (int'(t) * 3 + int'(y) * 8 + int'(x)) % ((1 << COLOR_IDX_W) - 1) + 1;
    return COLOR_IDX_W'(v);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_data <= '0;
    else
      o_data <= pixelAt(w_tile, w_row, w_col);
  end

endmodule

// File: rtl/tile_layer_renderer.sv
// Scrolling tiled background: screen coordinate -> world coordinate -> tile map
// entry -> (flipped) tile ROM pixel -> palette, one pixel per clock.
module tile_layer_renderer
  import tile_layer_pkg::*;
#(
  parameter int TILE_W      = DEF_TILE_W,
  parameter int TILE_H      = DEF_TILE_H,
  parameter int MAP_COLS    = DEF_MAP_COLS,
  parameter int MAP_ROWS    = DEF_MAP_ROWS,
  parameter int TILE_IDX_W  = DEF_TILE_IDX_W,
  parameter int COLOR_IDX_W = DEF_COLOR_IDX_W,
  localparam int MAP_AW     = $clog2(MAP_COLS * MAP_ROWS)
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic                  frame_start,
  input  logic [9:0]            scroll_x,
  input  logic [9:0]            scroll_y,
  input  logic                  map_we,
  input  logic [MAP_AW-1:0]     map_waddr,
  input  logic [TILE_IDX_W+1:0] map_wdata,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  opaque
);

  localparam int PIX_W  = MAP_COLS * TILE_W;
  localparam int PIX_H  = MAP_ROWS * TILE_H;
  localparam int ROM_AW = TILE_IDX_W + $clog2(TILE_H) + $clog2(TILE_W);

  logic [COORD_W-1:0]     r_sx_act;
  logic [COORD_W-1:0]     r_sy_act;
  s0_t                    r_s0;
  s1_t                    r_s1;
  logic                   r_blank2;
  logic                   r_blank3;
  logic [ROM_AW-1:0]      r_rom_addr;

  logic [COORD_W:0]       w_wx;
  logic [COORD_W:0]       w_wy;
  logic [MAP_AW-1:0]      w_map_raddr;
  logic [TILE_IDX_W+1:0]  w_map_rdata;
  map_entry_t             w_entry;
  logic [COORD_W-1:0]     w_fx_f;
  logic [COORD_W-1:0]     w_fy_f;
  logic [COLOR_IDX_W-1:0] w_pix;
  logic [3:0]             w_red;
  logic [3:0]             w_green;
  logic [3:0]             w_blue;

  assign w_wx        = wrap_coord(DrawX, r_sx_act, PIX_W);
  assign w_wy        = wrap_coord(DrawY, r_sy_act, PIX_H);
  assign w_map_raddr = MAP_AW'(int'(r_s0.ty) * MAP_COLS + int'(r_s0.tx));
  assign w_entry     = map_entry_t'(w_map_rdata);
  assign w_fx_f      = w_entry.flip_x ? COORD_W'(TILE_W - 1) - r_s1.fx : r_s1.fx;
  assign w_fy_f      = w_entry.flip_y ? COORD_W'(TILE_H - 1) - r_s1.fy : r_s1.fy;

  // Scroll is shadowed to frame boundaries; S0, S1 sidecar and S2 address stage.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sx_act   <= '0;
      r_sy_act   <= '0;
      r_s0       <= '0;
      r_s1       <= '0;
      r_blank2   <= 1'b0;
      r_blank3   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      if (frame_start) begin
        r_sx_act <= scroll_x;
        r_sy_act <= scroll_y;
      end
      r_s0.blank <= blank;
      r_s0.tx    <= COORD_W'(w_wx / TILE_W);
      r_s0.fx    <= COORD_W'(w_wx % TILE_W);
      r_s0.ty    <= COORD_W'(w_wy / TILE_H);
      r_s0.fy    <= COORD_W'(w_wy % TILE_H);
      r_s1.blank <= r_s0.blank;
      r_s1.fx    <= r_s0.fx;
      r_s1.fy    <= r_s0.fy;
      r_blank2   <= r_s1.blank;
      r_blank3   <= r_blank2;
      r_rom_addr <= ROM_AW'(int'(w_entry.tile_idx) * TILE_W * TILE_H
                            + int'(w_fy_f) * TILE_W + int'(w_fx_f));
    end
  end

  tile_map_ram #(
    .DEPTH  (MAP_COLS * MAP_ROWS),
    .DATA_W (TILE_IDX_W + 2)
  ) u_map (
    .i_clk   (vga_clk),
    .i_we    (map_we),
    .i_waddr (map_waddr),
    .i_wdata (map_wdata),
    .i_raddr (w_map_raddr),
    .o_rdata (w_map_rdata)
  );

  tile_rom #(
    .TILE_W      (TILE_W),
    .TILE_H      (TILE_H),
    .TILE_IDX_W  (TILE_IDX_W),
    .COLOR_IDX_W (COLOR_IDX_W)
  ) u_rom (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_addr  (r_rom_addr),
    .o_data  (w_pix)
  );

  tile_palette #(
    .COLOR_IDX_W (COLOR_IDX_W)
  ) u_pal (
    .i_idx   (w_pix),
    .o_red   (w_red),
    .o_green (w_green),
    .o_blue  (w_blue)
  );

  // Colour index 0 and blanked pixels both come out black and non-opaque.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end else if (r_blank3 && (w_pix != '0)) begin
      red    <= w_red;
      green  <= w_green;
      blue   <= w_blue;
      opaque <= 1'b1;
    end else begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end
  end

endmodule

// File: doc/tile_layer_renderer.md
# tile_layer_renderer

Parametrised tiled-background renderer for the VGA path. It replaces fixed full-screen image mappers with a writable tile map that indexes a shared tile-pixel ROM, with per-frame X/Y scroll and per-tile flip. It sits between the VGA controller (DrawX/DrawY/blank) and the colour output pins. The tile map is written from the same clock domain by game logic.

## Interface
- TILE_W, 16, tile width in pixels (power of 2)
- TILE_H, 16, tile height in pixels (power of 2)
- MAP_COLS, 40, map width in tiles
- MAP_ROWS, 30, map height in tiles
- TILE_IDX_W, 7, tile index width (128 tiles)
- COLOR_IDX_W, 6, palette index width
- vga_clk  in  1  pixel clock, sole clock
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate from VGA controller
- blank  in  1  1 = active video (display enabled)
- frame_start  in  1  one-cycle pulse at start of vertical blank
- scroll_x, scroll_y  in  10 each  requested scroll; scroll_x < MAP_COLS*TILE_W, scroll_y < MAP_ROWS*TILE_H
- map_we  in  1  tile-map write strobe
- map_waddr  in  $clog2(MAP_COLS*MAP_ROWS)  entry address, row-major
- map_wdata  in  TILE_IDX_W+2  {flip_y, flip_x, tile_idx}
- red, green, blue  out  4 each  registered colour
- opaque  out  1  registered; 1 when pixel colour index is non-zero and active

## Operation
- Scroll shadowing: scroll_x/scroll_y are captured into active registers only on frame_start, so there is no mid-frame tearing.
- S0 (register): wx = DrawX + sx_act, minus MAP_COLS*TILE_W if the sum is at or above it. A single conditional subtract suffices because DrawX ≤ 639 ≤ map width. wy is computed the same way with MAP_ROWS*TILE_H. Outputs are tx = wx/TILE_W, fx = wx%TILE_W, ty, fy.
- S1: map RAM synchronous read at ty*MAP_COLS + tx. fx/fy are delayed alongside.
- S2: fx' = flip_x ? TILE_W-1-fx : fx, and fy' likewise. Tile ROM synchronous read at tile_idx*TILE_W*TILE_H + fy'*TILE_W + fx'.
- S3: the palette is combinational on the ROM data and the result is registered to the outputs.
- blank is delayed through S0–S2 in step with the data.
- At S3, when the delayed blank is 0, outputs are 0 and opaque = 0.
- Colour index 0 is transparent. It gives RGB 0 and opaque = 0.
- Map write port: 1 write per cycle, with priority over nothing (dual-port RAM).
- When a write and a read hit the same address in the same cycle, the read returns the old data.
- Map contents are not reset.
- Reset: red/green/blue = 0, opaque = 0, active scroll = 0, all pipeline registers and the blank delay line = 0.
- Reset asserted mid-line forces the outputs to 0 immediately (asynchronous). The first valid pixel appears 4 cycles after reset_n deasserts.

## Timing
- Latency: DrawX/DrawY/blank sampled at edge N produce RGB/opaque valid after edge N+4. The VGA controller aligns hsync/vsync by delaying them 4 cycles.
- Throughput: 1 pixel per vga_clk with no stalls.
- frame_start is sampled on the edge where it is high. The new scroll applies to pixels sampled from the following edge onward.
- A map write at edge N is visible to S1 reads issued at edge N+1 or later.

## Structure
- Package tile_layer_pkg holds:
  - map entry struct {flip_y, flip_x, tile_idx}
  - pipeline stage structs
  - MAP_PIX_W/MAP_PIX_H localparams
  - the 4-cycle LATENCY constant, for use by the VGA controller
- Sub-module tile_map_ram: simple dual-port synchronous RAM, read-first, with MAP_COLS*MAP_ROWS entries of TILE_IDX_W+2 bits.
- The tile ROM and palette are instantiated in the same style as the existing image ROM/palette modules.

## Test plan
- Reset, then identity map (entry k = tile k%128), no scroll, DrawX=17, DrawY=0, blank=1 → after 4 cycles RGB equals palette[rom[1*256+1]].
- scroll_x=630 latched by frame_start, DrawX=15 → wx=5, tx=0, fx=5. scroll_x changed without frame_start → output unchanged.
- Entry 0 = {flip_x=1, idx=3}, DrawX=0 → fetches ROM pixel fx=15 of tile 3. With flip_y also set, DrawY=2 → fy=13.
- Transparent tile (all indices 0) → RGB=0 and opaque=0. blank=0 at cycle N → RGB=0 at N+4 regardless of map contents.
- map_we to address 41 while DrawX/DrawY read tile (1,1) in the same cycle → old tile shown. The next read shows the new tile.
- Assert reset_n low mid-line → outputs 0 asynchronously. After release, outputs stay 0 for 4 cycles and active scroll reads 0.
